imm_gen_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational immediate builder.
- Sits between instruction fetch/decode and the register-read/ALU operand mux.
- Accepts one instruction per cycle under valid/ready handshake, builds an XLEN-wide sign-extended immediate, and buffers results in a DEPTH-entry output FIFO with tag passthrough and flush.

---
 rtl/imm_gen_pipe.sv | 179 +++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: one instruction per cycle in, XLEN-wide immediates out through a DEPTH-entry FIFO.
// Optional per-format push counters are enabled by defining IMM_GEN_PERF_CNT_EN.
module imm_gen_pipe #(
   parameter int XLEN       = 32,
   parameter int DEPTH      = 2,
   parameter int TAG_W      = 5,
   parameter int SHAMT_MASK = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [2:0]       in_type,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_type,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_bad_type
`ifdef IMM_GEN_PERF_CNT_EN
   ,
   input  logic [2:0]       cnt_sel,
   output logic [31:0]      cnt_value
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   generate
      if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
         $error("imm_gen_pipe: XLEN must be 32 or 64");
      end
      if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
         $error("imm_gen_pipe: DEPTH must be a power of two >= 2");
      end
   endgenerate

   // Every format is assembled as a 32-bit signed value and then sign-extended to XLEN.
   function automatic logic signed [XLEN-1:0] build_imm(input logic [31:0] instr,
                                                        input logic [2:0]  fmt);
      logic signed [31:0] v;
      v = '0;
      case (fmt)
         3'd1: begin
            if (SHAMT_MASK != 0 && instr[6:0] == 7'b0010011 && instr[13:12] == 2'b01) begin
               v[10] = instr[30];
               if (XLEN == 64) v[5:0] = instr[25:20];
               else            v[4:0] = instr[24:20];
            end else begin
               v = {{20{instr[31]}}, instr[31:20]};
            end
         end
         3'd2:    v = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         3'd3:    v = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
         3'd4:    v = {instr[31:12], 12'b0};
         3'd5:    v = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
         default: v = '0;
      endcase
      return XLEN'(v);
   endfunction

   logic signed [XLEN-1:0] imm_mem [DEPTH];
   logic [2:0]             type_mem [DEPTH];
   logic [TAG_W-1:0]       tag_mem [DEPTH];

   logic [CNT_W-1:0]       count_q, count_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic signed [XLEN-1:0] out_imm_q, out_imm_d;
   logic [2:0]             out_type_q, out_type_d;
   logic [TAG_W-1:0]       out_tag_q, out_tag_d;
   logic                   out_bad_q, out_bad_d;
   logic signed [XLEN-1:0] new_imm;
   logic                   push, pop;

   assign new_imm   = build_imm(in_instr, in_type);
   assign out_valid = (count_q != '0);
   assign pop       = out_valid & out_ready;
   assign in_ready  = (count_q < FULL) | pop;
   assign push      = in_valid & in_ready;

   // The head copy is refreshed from the entry that becomes head; an entry pushed into an
   // empty (or emptying) FIFO bypasses the array. Head registers hold when the FIFO drains.
   always_comb begin
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      out_imm_d  = out_imm_q;
      out_type_d = out_type_q;
      out_tag_d  = out_tag_q;
      out_bad_d  = out_bad_q;
      if (flush) begin
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
         if (count_d != '0) begin
            if (push && wr_ptr_q == rd_ptr_d) begin
               out_imm_d  = new_imm;
               out_type_d = in_type;
               out_tag_d  = in_tag;
               out_bad_d  = in_type[2] & in_type[1];
            end else begin
               out_imm_d  = imm_mem[rd_ptr_d];
               out_type_d = type_mem[rd_ptr_d];
               out_tag_d  = tag_mem[rd_ptr_d];
               out_bad_d  = type_mem[rd_ptr_d][2] & type_mem[rd_ptr_d][1];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         imm_mem[wr_ptr_q]  <= new_imm;
         type_mem[wr_ptr_q] <= in_type;
         tag_mem[wr_ptr_q]  <= in_tag;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         out_imm_q  <= '0;
         out_type_q <= '0;
         out_tag_q  <= '0;
         out_bad_q  <= 1'b0;
      end else begin
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         out_imm_q  <= out_imm_d;
         out_type_q <= out_type_d;
         out_tag_q  <= out_tag_d;
         out_bad_q  <= out_bad_d;
      end
   end

   assign out_imm      = out_imm_q;
   assign out_type     = out_type_q;
   assign out_tag      = out_tag_q;
   assign out_bad_type = out_bad_q;

`ifdef IMM_GEN_PERF_CNT_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] c);
      return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
   endfunction

   logic [31:0] cnt_q [8];
   logic [31:0] cnt_value_q;

   // Counters track accepted pushes, so flush does not clear them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
         cnt_value_q <= '0;
      end else begin
         if (push) cnt_q[in_type] <= sat_inc(cnt_q[in_type]);
         cnt_value_q <= cnt_q[cnt_sel];
      end
   end

   assign cnt_value = cnt_value_q;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a 32-bit/DEPTH=2/shamt-masked instance and a 64-bit/DEPTH=4/plain instance share stimulus.
module tb_imm_gen_pipe;
   logic        clk = 1'b0;
   logic        reset, flush, in_valid, out_ready;
   logic [31:0] in_instr;
   logic [2:0]  in_type;
   logic [4:0]  in_tag;

   logic        a_in_ready, a_out_valid, a_bad;
   logic [31:0] a_imm;
   logic [2:0]  a_type;
   logic [4:0]  a_tag;
   logic        b_in_ready, b_out_valid, b_bad;
   logic [63:0] b_imm;
   logic [2:0]  b_type;
   logic [4:0]  b_tag;
`ifdef IMM_GEN_PERF_CNT_EN
   logic [2:0]  cnt_sel;
   logic [31:0] a_cnt, b_cnt;
`endif

   int checks = 0;
   int passed = 0;

   typedef struct packed {
      logic [2:0]  ty;
      logic [31:0] ins;
      logic [31:0] e32;
      logic [63:0] e64;
   } vec_t;
   vec_t vecs [18];

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .DEPTH(2), .TAG_W(5), .SHAMT_MASK(1)) u_a (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_instr(in_instr), .in_type(in_type), .in_tag(in_tag), .out_valid(a_out_valid),
      .out_ready(out_ready), .out_imm(a_imm), .out_type(a_type), .out_tag(a_tag),
      .out_bad_type(a_bad)
`ifdef IMM_GEN_PERF_CNT_EN
      , .cnt_sel(cnt_sel), .cnt_value(a_cnt)
`endif
   );

   imm_gen_pipe #(.XLEN(64), .DEPTH(4), .TAG_W(5), .SHAMT_MASK(0)) u_b (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_instr(in_instr), .in_type(in_type), .in_tag(in_tag), .out_valid(b_out_valid),
      .out_ready(out_ready), .out_imm(b_imm), .out_type(b_type), .out_tag(b_tag),
      .out_bad_type(b_bad)
`ifdef IMM_GEN_PERF_CNT_EN
      , .cnt_sel(cnt_sel), .cnt_value(b_cnt)
`endif
   );

   task automatic send(input logic [2:0] t, input logic [31:0] ins, input logic [4:0] tg);
      in_valid = 1'b1;
      in_type  = t;
      in_instr = ins;
      in_tag   = tg;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = '0; in_type = '0; in_tag = '0;
`ifdef IMM_GEN_PERF_CNT_EN
      cnt_sel = '0;
`endif
      repeat (2) @(negedge clk);
      checks++; if (a_out_valid !== 1'b0) $display("FAIL reset a_out_valid got %b want 0", a_out_valid); else passed++;
      checks++; if (a_imm !== 32'h0) $display("FAIL reset a_imm got %h want 0", a_imm); else passed++;
      checks++; if (a_type !== 3'd0) $display("FAIL reset a_type got %0d want 0", a_type); else passed++;
      checks++; if (a_tag !== 5'd0) $display("FAIL reset a_tag got %0d want 0", a_tag); else passed++;
      checks++; if (a_bad !== 1'b0) $display("FAIL reset a_bad got %b want 0", a_bad); else passed++;
      checks++; if (b_out_valid !== 1'b0) $display("FAIL reset b_out_valid got %b want 0", b_out_valid); else passed++;
      checks++; if (b_imm !== 64'h0) $display("FAIL reset b_imm got %h want 0", b_imm); else passed++;
      reset = 1'b0;
      @(negedge clk);
      checks++; if (a_in_ready !== 1'b1) $display("FAIL reset a_in_ready got %b want 1", a_in_ready); else passed++;
      checks++; if (b_in_ready !== 1'b1) $display("FAIL reset b_in_ready got %b want 1", b_in_ready); else passed++;
   endtask

   task automatic test_imm_formats;
      logic bad;
      vecs = '{
         '{3'd1, 32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF},
         '{3'd1, 32'h07B00093, 32'h0000007B, 64'h000000000000007B},
         '{3'd3, 32'hFE000EE3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC},
         '{3'd3, 32'h00208463, 32'h00000008, 64'h0000000000000008},
         '{3'd1, 32'h40305093, 32'h00000403, 64'h0000000000000403},
         '{3'd1, 32'h01F09093, 32'h0000001F, 64'h000000000000001F},
         '{3'd1, 32'hC0305093, 32'h00000403, 64'hFFFFFFFFFFFFFC03},
         '{3'd1, 32'hC0300093, 32'hFFFFFC03, 64'hFFFFFFFFFFFFFC03},
         '{3'd1, 32'hC0305003, 32'hFFFFFC03, 64'hFFFFFFFFFFFFFC03},
         '{3'd2, 32'hFE112E23, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC},
         '{3'd2, 32'h00112423, 32'h00000008, 64'h0000000000000008},
         '{3'd4, 32'h12345037, 32'h12345000, 64'h0000000012345000},
         '{3'd4, 32'hFFFFF037, 32'hFFFFF000, 64'hFFFFFFFFFFFFF000},
         '{3'd5, 32'hFF9FF0EF, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8},
         '{3'd0, 32'h002081B3, 32'h00000000, 64'h0000000000000000},
         '{3'd6, 32'hFFFFFFFF, 32'h00000000, 64'h0000000000000000},
         '{3'd7, 32'hFFFFFFFF, 32'h00000000, 64'h0000000000000000},
         '{3'd5, 32'h0080006F, 32'h00000008, 64'h0000000000000008}
      };
      out_ready = 1'b1;
      for (int i = 0; i < 18; i++) begin
         send(vecs[i].ty, vecs[i].ins, 5'(i));
         bad = (vecs[i].ty >= 3'd6);
         checks++; if (a_out_valid !== 1'b1) $display("FAIL fmt%0d a_out_valid got %b want 1", i, a_out_valid); else passed++;
         checks++; if (a_imm !== vecs[i].e32) $display("FAIL fmt%0d a_imm got %h want %h", i, a_imm, vecs[i].e32); else passed++;
         checks++; if (a_type !== vecs[i].ty) $display("FAIL fmt%0d a_type got %0d want %0d", i, a_type, vecs[i].ty); else passed++;
         checks++; if (a_tag !== 5'(i)) $display("FAIL fmt%0d a_tag got %0d want %0d", i, a_tag, i); else passed++;
         checks++; if (a_bad !== bad) $display("FAIL fmt%0d a_bad got %b want %b", i, a_bad, bad); else passed++;
         checks++; if (b_imm !== vecs[i].e64) $display("FAIL fmt%0d b_imm got %h want %h", i, b_imm, vecs[i].e64); else passed++;
         checks++; if (b_bad !== bad) $display("FAIL fmt%0d b_bad got %b want %b", i, b_bad, bad); else passed++;
      end
      @(negedge clk);
      checks++; if (a_out_valid !== 1'b0) $display("FAIL drain a_out_valid got %b want 0", a_out_valid); else passed++;
      checks++; if (a_imm !== 32'h8) $display("FAIL hold a_imm got %h want 8", a_imm); else passed++;
      checks++; if (b_imm !== 64'h8) $display("FAIL hold b_imm got %h want 8", b_imm); else passed++;
   endtask

   task automatic test_back_to_back;
      out_ready = 1'b0;
      in_valid = 1'b1; in_type = 3'd1; in_instr = {7'd0, 5'd0, 20'h00093}; in_tag = 5'd0;
      @(negedge clk);
      in_instr = {7'd0, 5'd1, 20'h00093}; in_tag = 5'd1;
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (a_in_ready !== 1'b0) $display("FAIL full a_in_ready got %b want 0", a_in_ready); else passed++;
      checks++; if (b_in_ready !== 1'b1) $display("FAIL full b_in_ready got %b want 1", b_in_ready); else passed++;
      checks++; if (a_tag !== 5'd0) $display("FAIL full a_tag got %0d want 0", a_tag); else passed++;
      out_ready = 1'b1;
      in_valid = 1'b1; in_instr = {7'd0, 5'd2, 20'h00093}; in_tag = 5'd2;
      #1;
      checks++; if (a_in_ready !== 1'b1) $display("FAIL popfree a_in_ready got %b want 1", a_in_ready); else passed++;
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (a_tag !== 5'd1) $display("FAIL order1 a_tag got %0d want 1", a_tag); else passed++;
      checks++; if (a_imm !== 32'd1) $display("FAIL order1 a_imm got %h want 1", a_imm); else passed++;
      checks++; if (b_tag !== 5'd1) $display("FAIL order1 b_tag got %0d want 1", b_tag); else passed++;
      @(negedge clk);
      checks++; if (a_tag !== 5'd2) $display("FAIL order2 a_tag got %0d want 2", a_tag); else passed++;
      checks++; if (a_imm !== 32'd2) $display("FAIL order2 a_imm got %h want 2", a_imm); else passed++;
      checks++; if (b_tag !== 5'd2) $display("FAIL order2 b_tag got %0d want 2", b_tag); else passed++;
      @(negedge clk);
      checks++; if (a_out_valid !== 1'b0) $display("FAIL empty a_out_valid got %b want 0", a_out_valid); else passed++;
      checks++; if (b_out_valid !== 1'b0) $display("FAIL empty b_out_valid got %b want 0", b_out_valid); else passed++;
   endtask

   task automatic test_flush;
      out_ready = 1'b0;
      send(3'd1, {7'd0, 5'd3, 20'h00093}, 5'd3);
      send(3'd1, {7'd0, 5'd4, 20'h00093}, 5'd4);
      flush = 1'b1;
      in_valid = 1'b1; in_type = 3'd1; in_instr = {7'd0, 5'd5, 20'h00093}; in_tag = 5'd5;
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      checks++; if (a_out_valid !== 1'b0) $display("FAIL flush a_out_valid got %b want 0", a_out_valid); else passed++;
      checks++; if (b_out_valid !== 1'b0) $display("FAIL flush b_out_valid got %b want 0", b_out_valid); else passed++;
      checks++; if (a_in_ready !== 1'b1) $display("FAIL flush a_in_ready got %b want 1", a_in_ready); else passed++;
      checks++; if (a_imm !== 32'd3) $display("FAIL flush hold a_imm got %h want 3", a_imm); else passed++;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (a_out_valid !== 1'b0) $display("FAIL flushdrop a_out_valid got %b want 0", a_out_valid); else passed++;
      checks++; if (b_out_valid !== 1'b0) $display("FAIL flushdrop b_out_valid got %b want 0", b_out_valid); else passed++;
      send(3'd1, {7'd0, 5'd6, 20'h00093}, 5'd6);
      checks++; if (a_out_valid !== 1'b1) $display("FAIL postflush a_out_valid got %b want 1", a_out_valid); else passed++;
      checks++; if (a_tag !== 5'd6) $display("FAIL postflush a_tag got %0d want 6", a_tag); else passed++;
      checks++; if (b_tag !== 5'd6) $display("FAIL postflush b_tag got %0d want 6", b_tag); else passed++;
      @(negedge clk);
   endtask

   task automatic test_reset_midstream;
      out_ready = 1'b0;
      send(3'd2, 32'hFE112E23, 5'd7);
      send(3'd1, 32'hFFF00093, 5'd8);
      #2 reset = 1'b1;
      #1;
      checks++; if (a_out_valid !== 1'b0) $display("FAIL midrst a_out_valid got %b want 0", a_out_valid); else passed++;
      checks++; if (a_imm !== 32'h0) $display("FAIL midrst a_imm got %h want 0", a_imm); else passed++;
      checks++; if (a_tag !== 5'd0) $display("FAIL midrst a_tag got %0d want 0", a_tag); else passed++;
      checks++; if (b_out_valid !== 1'b0) $display("FAIL midrst b_out_valid got %b want 0", b_out_valid); else passed++;
      checks++; if (b_imm !== 64'h0) $display("FAIL midrst b_imm got %h want 0", b_imm); else passed++;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++; if (a_in_ready !== 1'b1) $display("FAIL midrst a_in_ready got %b want 1", a_in_ready); else passed++;
      checks++; if (a_out_valid !== 1'b0) $display("FAIL midrst2 a_out_valid got %b want 0", a_out_valid); else passed++;
   endtask

`ifdef IMM_GEN_PERF_CNT_EN
   task automatic test_perf_cnt;
      out_ready = 1'b1;
      send(3'd7, 32'hFFFFFFFF, 5'd9);
      checks++; if (a_bad !== 1'b1) $display("FAIL perf a_bad got %b want 1", a_bad); else passed++;
      cnt_sel = 3'd7;
      @(negedge clk);
      checks++; if (a_cnt !== 32'd1) $display("FAIL perf a_cnt7 got %0d want 1", a_cnt); else passed++;
      checks++; if (b_cnt !== 32'd1) $display("FAIL perf b_cnt7 got %0d want 1", b_cnt); else passed++;
      cnt_sel = 3'd6;
      @(negedge clk);
      checks++; if (a_cnt !== 32'd0) $display("FAIL perf a_cnt6 got %0d want 0", a_cnt); else passed++;
   endtask
`endif

   initial begin
      test_reset();
      test_imm_formats();
      test_back_to_back();
      test_flush();
      test_reset_midstream();
`ifdef IMM_GEN_PERF_CNT_EN
      test_perf_cnt();
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
